// File: rtl/ddr_wr_pkg.sv
// Shared constants and state encoding for the DDR frame writer.
package ddr_wr_pkg;
    localparam int PIX_W         = 16;
    localparam int WORD_W        = 256;
    localparam int PIX_PER_WORD  = 16;
    localparam int ADDR_W        = 28;
    localparam int BEAT_ADDR_INC = 8;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } wr_state_t;
endpackage

// File: rtl/ddr_frame_writer_fifo.sv
// Show-ahead single-clock word FIFO. A flush trims the queue down to its oldest
// flush_keep entries, so a burst already promised to the controller survives.
module sync_word_fifo
    import ddr_wr_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int W     = WORD_W
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [$clog2(DEPTH):0] flush_keep,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PW  = $clog2(DEPTH);
    localparam int PW1 = PW + 1;
    localparam logic [PW:0] FULL_CNT = PW1'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW:0]   r_count;
    logic          w_push_ok;
    logic          w_pop_ok;
    logic [PW-1:0] w_rd_nxt;

    if ((1 << PW) != DEPTH) begin : g_depth_check
        $error("sync_word_fifo: DEPTH must be a power of two");
    end

    assign full  = (r_count == FULL_CNT);
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = empty ? '0 : r_mem[r_rd_ptr];

    // A word arriving during a flush belongs to the abandoned frame.
    assign w_push_ok = push & ~full & ~flush;
    assign w_pop_ok  = pop & ~empty;
    assign w_rd_nxt  = r_rd_ptr + PW'(w_pop_ok);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_rd_ptr <= w_rd_nxt;
            if (flush) begin
                r_wr_ptr <= w_rd_nxt + PW'(flush_keep);
                r_count  <= flush_keep;
            end else begin
                r_wr_ptr <= r_wr_ptr + PW'(w_push_ok);
                r_count  <= r_count + PW1'(w_push_ok) - PW1'(w_pop_ok);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end
endmodule

// File: rtl/ddr_frame_writer.sv
// AXI write master: packs RGB565 pixels into 256-bit words, buffers them and
// writes fixed-length bursts into a linear frame buffer on the DDR controller.
module ddr_frame_writer
    import ddr_wr_pkg::*;
#(
    parameter int          H_ACT      = 1280,
    parameter int          V_ACT      = 720,
    parameter int          BURST_LEN  = 16,
    parameter logic [27:0] FRAME_BASE = 28'h0,
    parameter int          FIFO_DEPTH = 32,
    parameter logic [3:0]  AXI_ID     = 4'h0
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         vsync,
    input  logic         de,
    input  logic [15:0]  pixel,
    output logic [27:0]  axi_awaddr,
    output logic         axi_awuser_ap,
    output logic [3:0]   axi_awuser_id,
    output logic [3:0]   axi_awlen,
    output logic         axi_awvalid,
    input  logic         axi_awready,
    output logic [255:0] axi_wdata,
    output logic [31:0]  axi_wstrb,
    input  logic         axi_wready,
    input  logic [3:0]   axi_wusero_id,
    input  logic         axi_wusero_last,
    output logic         frame_done,
    output logic         overflow
);
    localparam int BURSTS_PER_FRAME = (H_ACT * V_ACT) / (PIX_PER_WORD * BURST_LEN);
    localparam int BC_W      = $clog2(BURSTS_PER_FRAME + 1);
    localparam int BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int ADDR_STEP = BURST_LEN * BEAT_ADDR_INC;

    if (((H_ACT * V_ACT) % (PIX_PER_WORD * BURST_LEN)) != 0) begin : g_frame_check
        $error("ddr_frame_writer: H_ACT*V_ACT must be a multiple of 16*BURST_LEN");
    end
    if (FIFO_DEPTH < 2 * BURST_LEN) begin : g_depth_check
        $error("ddr_frame_writer: FIFO_DEPTH must be at least 2*BURST_LEN");
    end

    logic                r_vsync_d;
    logic                w_frame_start;
    logic [3:0]          r_phase;
    logic [WORD_W-1:0]   r_word;
    logic                w_word_done;
    logic [WORD_W-1:0]   w_word;
    logic                r_overflow;

    wr_state_t           r_state;
    wr_state_t           w_state_nxt;
    logic                w_awvalid;
    logic [CNT_W-1:0]    w_keep;
    logic [BEAT_W-1:0]   r_beat;
    logic [BC_W-1:0]     r_burst_cnt;
    logic [ADDR_W-1:0]   r_awaddr;
    logic                r_addr_rst_pend;
    logic                r_frame_done;
    logic                w_pop;
    logic                w_last_beat;
    logic                w_burst_end;

    logic [CNT_W-1:0]    w_fifo_count;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_unused;

    assign w_unused = ^{axi_wusero_id, axi_wusero_last};

    assign w_frame_start = vsync & ~r_vsync_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vsync_d <= 1'b0;
        end else begin
            r_vsync_d <= vsync;
        end
    end

    // Pixel k of a word lands in bits [16k+15:16k]; the 16th pixel completes it.
    assign w_word_done = de & (r_phase == 4'hF) & ~w_frame_start;
    assign w_word      = {pixel, r_word[WORD_W-PIX_W-1:0]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_phase <= 4'h0;
        end else if (w_frame_start) begin
            r_phase <= 4'h0;
        end else if (de) begin
            r_phase <= r_phase + 4'h1;
        end
    end

    always_ff @(posedge clk) begin
        if (de) begin
            r_word[{r_phase, 4'h0} +: PIX_W] <= pixel;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_overflow <= 1'b0;
        end else if (w_frame_start) begin
            r_overflow <= 1'b0;
        end else if (w_word_done && w_fifo_full) begin
            r_overflow <= 1'b1;
        end
    end

    sync_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (WORD_W)
    ) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push       (w_word_done),
        .pop        (w_pop),
        .flush      (w_frame_start),
        .flush_keep (w_keep),
        .din        (w_word),
        .dout       (axi_wdata),
        .count      (w_fifo_count),
        .full       (w_fifo_full),
        .empty      (w_fifo_empty)
    );

    assign w_pop       = (r_state == DATA) & axi_wready & ~w_fifo_empty;
    assign w_last_beat = (r_beat == BEAT_W'(BURST_LEN - 1));
    assign w_burst_end = w_pop & w_last_beat;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // w_keep is how many FIFO words still belong to the burst in flight after
    // this cycle's pop; a frame restart flushes everything beyond them.
    always_comb begin
        w_state_nxt = r_state;
        w_awvalid   = 1'b0;
        w_keep      = '0;
        case (r_state)
            IDLE: begin
                if ((w_fifo_count >= CNT_W'(BURST_LEN)) && !w_frame_start) begin
                    w_state_nxt = ADDR;
                end
            end
            ADDR: begin
                w_awvalid = 1'b1;
                w_keep    = CNT_W'(BURST_LEN);
                if (axi_awready) begin
                    w_state_nxt = DATA;
                end
            end
            DATA: begin
                w_keep = CNT_W'(BURST_LEN) - CNT_W'(r_beat) - CNT_W'(w_pop);
                if (w_burst_end) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_beat <= '0;
        end else if (w_pop) begin
            r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
        end
    end

    // A frame restart during a burst only rewinds the address once it ends.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_awaddr        <= FRAME_BASE;
            r_burst_cnt     <= '0;
            r_addr_rst_pend <= 1'b0;
            r_frame_done    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_burst_end) begin
                if (r_addr_rst_pend || w_frame_start) begin
                    r_awaddr        <= FRAME_BASE;
                    r_burst_cnt     <= '0;
                    r_addr_rst_pend <= 1'b0;
                end else if (r_burst_cnt == BC_W'(BURSTS_PER_FRAME - 1)) begin
                    r_awaddr     <= FRAME_BASE;
                    r_burst_cnt  <= '0;
                    r_frame_done <= 1'b1;
                end else begin
                    r_awaddr    <= r_awaddr + ADDR_W'(ADDR_STEP);
                    r_burst_cnt <= r_burst_cnt + 1'b1;
                end
            end else if (w_frame_start) begin
                if (r_state == IDLE) begin
                    r_awaddr    <= FRAME_BASE;
                    r_burst_cnt <= '0;
                end else begin
                    r_addr_rst_pend <= 1'b1;
                end
            end
        end
    end

    assign axi_awaddr    = r_awaddr;
    assign axi_awvalid   = w_awvalid;
    assign axi_awuser_ap = 1'b0;
    assign axi_awuser_id = AXI_ID;
    assign axi_awlen     = 4'(BURST_LEN - 1);
    assign axi_wstrb     = '1;
    assign frame_done    = r_frame_done;
    assign overflow      = r_overflow;
endmodule

// File: tb/tb_ddr_frame_writer.sv
// Scoreboard bench for ddr_frame_writer on a reduced 128x16 frame (8 bursts).
`timescale 1ns/1ps
module tb_ddr_frame_writer;
    localparam int H  = 128;
    localparam int V  = 16;
    localparam int BL = 16;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         vsync = 1'b0;
    logic         de = 1'b0;
    logic [15:0]  pixel = 16'h0;
    logic [27:0]  axi_awaddr;
    logic         axi_awuser_ap;
    logic [3:0]   axi_awuser_id;
    logic [3:0]   axi_awlen;
    logic         axi_awvalid;
    logic         axi_awready = 1'b1;
    logic [255:0] axi_wdata;
    logic [31:0]  axi_wstrb;
    logic         axi_wready;
    logic         frame_done;
    logic         overflow;
    logic         wr_fixed = 1'b1;
    logic         wr_rand_en = 1'b0;
    logic         wr_rand = 1'b0;

    assign axi_wready = wr_rand_en ? wr_rand : wr_fixed;

    ddr_frame_writer #(
        .H_ACT(H), .V_ACT(V), .BURST_LEN(BL), .FRAME_BASE(28'h0),
        .FIFO_DEPTH(32), .AXI_ID(4'h0)
    ) dut (
        .clk(clk), .rstn(rstn), .vsync(vsync), .de(de), .pixel(pixel),
        .axi_awaddr(axi_awaddr), .axi_awuser_ap(axi_awuser_ap),
        .axi_awuser_id(axi_awuser_id), .axi_awlen(axi_awlen),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wready(axi_wready),
        .axi_wusero_id(4'h0), .axi_wusero_last(1'b0),
        .frame_done(frame_done), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        wr_rand = 1'($urandom_range(0, 1));
    end

    logic [255:0] exp_w[$];
    logic [27:0]  exp_aw[$];
    logic [255:0] acc = '0;
    int n_chk = 0;
    int n_err = 0;
    int beats_left = 0;
    int done_cnt = 0;
    int tb_phase = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: plays the controller side, pops expectations on each handshake.
    always @(negedge clk) begin
        if (rstn) begin
            if (axi_wready && beats_left > 0) begin
                if (exp_w.size() == 0) begin
                    chk("w_unexpected", 1'b1, 1'b0);
                end else begin
                    chk("wdata", axi_wdata, exp_w.pop_front());
                end
                beats_left--;
            end
            if (axi_awvalid && axi_awready) begin
                if (exp_aw.size() == 0) begin
                    chk("aw_unexpected", 1'b1, 1'b0);
                end else begin
                    chk("awaddr", 256'(axi_awaddr), 256'(exp_aw.pop_front()));
                end
                chk("awlen", 256'(axi_awlen), 256'(15));
                beats_left = BL;
            end
            if (frame_done) done_cnt++;
        end
    end

    task automatic send_pixels(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            de = 1'b1;
            pixel = 16'(base + i);
            acc[16*tb_phase +: 16] = pixel;
            if (tb_phase == 15) begin
                exp_w.push_back(acc);
                tb_phase = 0;
            end else begin
                tb_phase++;
            end
            @(posedge clk); #1;
        end
        de = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int t = 0;
        while ((exp_w.size() != 0 || exp_aw.size() != 0 || beats_left != 0) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        n_chk++;
        if (t >= 4000) begin
            n_err++;
            $display("FAIL %s: timeout with %0d words %0d addrs pending, expected 0",
                     nm, exp_w.size(), exp_aw.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_awvalid(input string nm);
        int t = 0;
        while (!axi_awvalid && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk(nm, 256'(axi_awvalid), 256'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] first;
        int t;
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_awvalid", 256'(axi_awvalid), 256'(0));
        chk("rst_awaddr", 256'(axi_awaddr), 256'(0));
        chk("rst_frame_done", 256'(frame_done), 256'(0));
        chk("rst_overflow", 256'(overflow), 256'(0));
        chk("rst_wdata", axi_wdata, 256'(0));
        chk("rst_wstrb", 256'(axi_wstrb), 256'(32'hFFFF_FFFF));
        chk("rst_awuser_id", 256'(axi_awuser_id), 256'(0));
        chk("rst_awuser_ap", 256'(axi_awuser_ap), 256'(0));
        rstn = 1'b1;
        @(posedge clk); #1;

        // First burst: pixels 0..255, word j holds pixels 16j..16j+15
        exp_aw.push_back(28'd0);
        send_pixels(256, 0);
        wait_drain("burst0");

        // AW stall: awvalid/awaddr/wdata frozen for 10 cycles
        axi_awready = 1'b0;
        exp_aw.push_back(28'd128);
        send_pixels(256, 256);
        wait_awvalid("stall_awvalid_up");
        first = exp_w[0];
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_awvalid", 256'(axi_awvalid), 256'(1));
            chk("stall_awaddr", 256'(axi_awaddr), 256'(128));
            chk("stall_wdata", axi_wdata, first);
        end
        @(posedge clk); #1;
        axi_awready = 1'b1;
        wait_drain("stall_burst");

        // Full reduced frame with random wready stalls
        vsync = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vsync = 1'b0;
        tb_phase = 0;
        chk("sync_awaddr", 256'(axi_awaddr), 256'(0));
        done_cnt = 0;
        for (int b = 0; b < 8; b++) exp_aw.push_back(28'(b * 128));
        wr_rand_en = 1'b1;
        send_pixels(H * V, 1000);
        wait_drain("frame");
        wr_rand_en = 1'b0;
        wr_fixed = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        chk("frame_done_count", 256'(done_cnt), 256'(1));
        chk("frame_wrap_awaddr", 256'(axi_awaddr), 256'(0));
        chk("frame_overflow", 256'(overflow), 256'(0));

        // Overflow: first burst drains, then wready stays low
        exp_aw.push_back(28'd0);
        send_pixels(256, 4096);
        wait_drain("ovf_burst0");
        wr_fixed = 1'b0;
        exp_aw.push_back(28'd128);
        send_pixels(32 * 16, 8192);
        chk("ovf_at_32_words", 256'(overflow), 256'(0));
        send_pixels(16, 8192 + 512);
        chk("ovf_at_33_words", 256'(overflow), 256'(1));
        vsync = 1'b1;
        @(posedge clk); #1;
        vsync = 1'b0;
        tb_phase = 0;
        chk("ovf_cleared", 256'(overflow), 256'(0));
        for (int i = 0; i < 17; i++) void'(exp_w.pop_back());
        wr_fixed = 1'b1;
        wait_drain("ovf_flush_burst");
        chk("ovf_addr_rewind", 256'(axi_awaddr), 256'(0));

        // vsync mid-burst at beat 5 with 8 words + 7 pixels buffered
        wr_fixed = 1'b0;
        exp_aw.push_back(28'd0);
        send_pixels(256, 12288);
        t = 0;
        while (beats_left != BL && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("vs_aw_accepted", 256'(beats_left), 256'(BL));
        @(posedge clk); #1;
        wr_fixed = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        wr_fixed = 1'b0;
        send_pixels(8 * 16 + 7, 16384);
        vsync = 1'b1;
        wr_fixed = 1'b1;
        @(posedge clk); #1;
        vsync = 1'b0;
        tb_phase = 0;
        for (int i = 0; i < 8; i++) void'(exp_w.pop_back());
        wait_drain("vs_remaining_beats");
        chk("vs_addr_rewind", 256'(axi_awaddr), 256'(0));
        exp_aw.push_back(28'd0);
        send_pixels(256, 20480);
        wait_drain("vs_next_burst");

        // Asynchronous reset while a burst waits in ADDR
        axi_awready = 1'b0;
        send_pixels(256, 24576);
        wait_awvalid("rst_pre_awvalid");
        chk("rst_pre_awaddr", 256'(axi_awaddr), 256'(128));
        #3;
        rstn = 1'b0;
        #1;
        chk("arst_awvalid", 256'(axi_awvalid), 256'(0));
        chk("arst_awaddr", 256'(axi_awaddr), 256'(0));
        chk("arst_wdata", axi_wdata, 256'(0));
        chk("arst_overflow", 256'(overflow), 256'(0));
        chk("arst_frame_done", 256'(frame_done), 256'(0));
        exp_w.delete();
        exp_aw.delete();
        beats_left = 0;
        tb_phase = 0;
        repeat (3) @(posedge clk);
        #3;
        rstn = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        chk("post_rst_awvalid", 256'(axi_awvalid), 256'(0));
        chk("post_rst_fifo_empty", axi_wdata, 256'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
